// File: rtl/ddr_reg_axi_responder.sv
// AXI4 register-bank responder for the 32-bit DDR configuration port (reg* bus).
// Optional macro REG_ERR_RESP_EN: out-of-page accesses answer SLVERR instead of aliasing.
module ddr_reg_axi_responder #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned ID_W       = 6
) (
    input  logic              regACLK,
    input  logic              regARESETn,
    input  logic [ADDR_W-1:0] regAWADDR,
    input  logic [ID_W-1:0]   regAWID,
    input  logic [7:0]        regAWLEN,
    input  logic [2:0]        regAWSIZE,
    input  logic [1:0]        regAWBURST,
    input  logic              regAWVALID,
    output logic              regAWREADY,
    input  logic [31:0]       regWDATA,
    input  logic [3:0]        regWSTRB,
    input  logic              regWLAST,
    input  logic              regWVALID,
    output logic              regWREADY,
    output logic [ID_W-1:0]   regBID,
    output logic [1:0]        regBRESP,
    output logic              regBVALID,
    input  logic              regBREADY,
    input  logic [ADDR_W-1:0] regARADDR,
    input  logic [ID_W-1:0]   regARID,
    input  logic [7:0]        regARLEN,
    input  logic [2:0]        regARSIZE,
    input  logic [1:0]        regARBURST,
    input  logic              regARVALID,
    output logic              regARREADY,
    output logic [31:0]       regRDATA,
    output logic [ID_W-1:0]   regRID,
    output logic [1:0]        regRRESP,
    output logic              regRLAST,
    output logic              regRVALID,
    input  logic              regRREADY,
    output logic              err_wlast
);

    localparam int unsigned DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [1:0]  BURST_FIXED = 2'b00;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [31:0] mem [DEPTH];

    logic [ID_W-1:0]       w_id, r_id;
    logic [DEPTH_LOG2-1:0] w_idx, r_idx, r_idx_nxt;
    logic [7:0]            w_len, w_beat, r_len, r_beat;
    logic                  w_fixed, r_fixed, w_err, r_err;
    logic                  aw_page_err, ar_page_err;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat;

    assign aw_hs       = regAWVALID & regAWREADY;
    assign w_hs        = regWVALID & regWREADY;
    assign b_hs        = regBVALID & regBREADY;
    assign ar_hs       = regARVALID & regARREADY;
    assign r_hs        = regRVALID & regRREADY;
    assign w_last_beat = (w_beat == w_len);
    assign r_idx_nxt   = r_fixed ? r_idx : r_idx + IDX_ONE;

`ifdef REG_ERR_RESP_EN
    assign aw_page_err = |regAWADDR[ADDR_W-1:DEPTH_LOG2+2];
    assign ar_page_err = |regARADDR[ADDR_W-1:DEPTH_LOG2+2];
    logic unused_bits;
    assign unused_bits = ^{regAWADDR[1:0], regARADDR[1:0], regAWSIZE, regARSIZE};
`else
    // Page bits alias onto the same bank
    assign aw_page_err = 1'b0;
    assign ar_page_err = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{regAWADDR[ADDR_W-1:DEPTH_LOG2+2], regARADDR[ADDR_W-1:DEPTH_LOG2+2],
                           regAWADDR[1:0], regARADDR[1:0], regAWSIZE, regARSIZE};
`endif

    // State registers
    always_ff @(posedge regACLK) begin
        if (!regARESETn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // Write next-state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Read next-state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_LOAD;
            R_LOAD:  r_next = R_DATA;
            R_DATA:  if (r_hs && regRLAST) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Write channel context and registered AW/W/B outputs
    always_ff @(posedge regACLK) begin
        if (!regARESETn) begin
            regAWREADY <= 1'b0;
            regWREADY  <= 1'b0;
            regBVALID  <= 1'b0;
            regBID     <= '0;
            regBRESP   <= RESP_OKAY;
            err_wlast  <= 1'b0;
            w_id       <= '0;
            w_idx      <= '0;
            w_len      <= '0;
            w_beat     <= '0;
            w_fixed    <= 1'b0;
            w_err      <= 1'b0;
        end else begin
            regAWREADY <= (w_next == W_IDLE);
            regWREADY  <= (w_next == W_DATA);
            regBVALID  <= (w_next == W_RESP);
            if (aw_hs) begin
                w_id    <= regAWID;
                w_idx   <= regAWADDR[DEPTH_LOG2+1:2];
                w_len   <= regAWLEN;
                w_beat  <= 8'd0;
                w_fixed <= (regAWBURST == BURST_FIXED);
                w_err   <= aw_page_err;
            end
            if (w_hs) begin
                if (regWLAST != w_last_beat) err_wlast <= 1'b1;
                if (!w_fixed) w_idx <= w_idx + IDX_ONE;
                w_beat <= w_beat + 8'd1;
                if (w_last_beat) begin
                    regBID   <= w_id;
                    regBRESP <= w_err ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    // Register bank with byte strobes; out-of-page beats are dropped
    always_ff @(posedge regACLK) begin
        if (!regARESETn) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'd0;
        end else if (w_hs && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (regWSTRB[b]) mem[w_idx][8*b +: 8] <= regWDATA[8*b +: 8];
            end
        end
    end

    // Read channel context and registered AR/R outputs
    always_ff @(posedge regACLK) begin
        if (!regARESETn) begin
            regARREADY <= 1'b0;
            regRVALID  <= 1'b0;
            regRDATA   <= 32'd0;
            regRID     <= '0;
            regRRESP   <= RESP_OKAY;
            regRLAST   <= 1'b0;
            r_id       <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_fixed    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            regARREADY <= (r_next == R_IDLE);
            regRVALID  <= (r_next == R_DATA);
            if (ar_hs) begin
                r_id    <= regARID;
                r_idx   <= regARADDR[DEPTH_LOG2+1:2];
                r_len   <= regARLEN;
                r_beat  <= 8'd0;
                r_fixed <= (regARBURST == BURST_FIXED);
                r_err   <= ar_page_err;
            end
            if (r_state == R_LOAD) begin
                regRDATA <= r_err ? 32'd0 : mem[r_idx];
                regRLAST <= (r_beat == r_len);
                regRID   <= r_id;
                regRRESP <= r_err ? RESP_SLVERR : RESP_OKAY;
            end else if (r_state == R_DATA && r_hs && !regRLAST) begin
                // Next word loads on the accepting edge so beats run back-to-back
                r_idx    <= r_idx_nxt;
                r_beat   <= r_beat + 8'd1;
                regRDATA <= r_err ? 32'd0 : mem[r_idx_nxt];
                regRLAST <= ((r_beat + 8'd1) == r_len);
            end
        end
    end

endmodule

// File: tb/tb_ddr_reg_axi_responder.sv
// Directed bench for ddr_reg_axi_responder; expectations are hand-computed constants.
module tb_ddr_reg_axi_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] awaddr, araddr;
    logic [5:0]  awid, arid, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready, err_wlast;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ddr_reg_axi_responder dut (
        .regACLK(clk), .regARESETn(rst_n),
        .regAWADDR(awaddr), .regAWID(awid), .regAWLEN(awlen), .regAWSIZE(awsize),
        .regAWBURST(awburst), .regAWVALID(awvalid), .regAWREADY(awready),
        .regWDATA(wdata), .regWSTRB(wstrb), .regWLAST(wlast), .regWVALID(wvalid),
        .regWREADY(wready), .regBID(bid), .regBRESP(bresp), .regBVALID(bvalid),
        .regBREADY(bready), .regARADDR(araddr), .regARID(arid), .regARLEN(arlen),
        .regARSIZE(arsize), .regARBURST(arburst), .regARVALID(arvalid),
        .regARREADY(arready), .regRDATA(rdata), .regRID(rid), .regRRESP(rresp),
        .regRLAST(rlast), .regRVALID(rvalid), .regRREADY(rready), .err_wlast(err_wlast)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic aw_send(input logic [14:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [1:0] burst);
        awaddr = a; awid = id; awlen = len; awburst = burst; awvalid = 1'b1;
        for (int i = 0; i < 100 && !awready; i++) tick();
        check("awready_wait", 32'(awready), 32'd1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        for (int i = 0; i < 100 && !wready; i++) tick();
        check("wready_wait", 32'(wready), 32'd1);
        tick();
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input logic [5:0] id, input logic [1:0] resp);
        bready = 1'b1;
        for (int i = 0; i < 100 && !bvalid; i++) tick();
        check("bvalid", 32'(bvalid), 32'd1);
        check("bid", 32'(bid), 32'(id));
        check("bresp", 32'(bresp), 32'(resp));
        tick();
        bready = 1'b0;
    endtask

    task automatic ar_send(input logic [14:0] a, input logic [5:0] id, input logic [7:0] len,
                           input logic [1:0] burst);
        araddr = a; arid = id; arlen = len; arburst = burst; arvalid = 1'b1;
        for (int i = 0; i < 100 && !arready; i++) tick();
        check("arready_wait", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [31:0] d, input logic [5:0] id,
                          input logic [1:0] resp, input logic last);
        rready = 1'b1;
        for (int i = 0; i < 100 && !rvalid; i++) tick();
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_rdata"}, rdata, d);
        check({tag, "_rid"}, 32'(rid), 32'(id));
        check({tag, "_rresp"}, 32'(rresp), 32'(resp));
        check({tag, "_rlast"}, 32'(rlast), 32'(last));
        tick();
        rready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, 32'(awready), 32'd0);
        check({tag, "_wready"}, 32'(wready), 32'd0);
        check({tag, "_bvalid"}, 32'(bvalid), 32'd0);
        check({tag, "_bid_bresp"}, 32'({bid, bresp}), 32'd0);
        check({tag, "_arready"}, 32'(arready), 32'd0);
        check({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_rid_rresp_rlast"}, 32'({rid, rresp, rlast}), 32'd0);
        check({tag, "_err_wlast"}, 32'(err_wlast), 32'd0);
    endtask

    initial begin
        logic [31:0] exp4 [4];
        exp4[0] = 32'd1; exp4[1] = 32'd2; exp4[2] = 32'd3; exp4[3] = 32'd4;
        rst_n = 1'b0;
        awaddr = '0; awid = '0; awlen = '0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arid = '0; arlen = '0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b0;
        rready = 1'b0;

        // Reset state
        tick(); tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: single write/read with RVALID latency
        aw_send(15'h0010, 6'd5, 8'd0, 2'b01);
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        b_recv(6'd5, 2'b00);
        ar_send(15'h0010, 6'd5, 8'd0, 2'b01);
        check("t1_rvalid_load", 32'(rvalid), 32'd0);
        tick();
        check("t1_rvalid_first", 32'(rvalid), 32'd1);
        r_recv("t1", 32'hDEADBEEF, 6'd5, 2'b00, 1'b1);

        // 2: INCR burst wrapping the bank, FIXED read
        aw_send(15'h00F8, 6'd7, 8'd3, 2'b01);
        for (int b = 0; b < 4; b++) w_send(exp4[b], 4'hF, (b == 3));
        b_recv(6'd7, 2'b00);
        ar_send(15'h00F8, 6'd8, 8'd3, 2'b01);
        for (int b = 0; b < 4; b++) r_recv("t2_incr", exp4[b], 6'd8, 2'b00, (b == 3));
        ar_send(15'h0000, 6'd9, 8'd1, 2'b00);
        r_recv("t2_fixed0", 32'd3, 6'd9, 2'b00, 1'b0);
        r_recv("t2_fixed1", 32'd3, 6'd9, 2'b00, 1'b1);

        // 3: byte strobes
        aw_send(15'h0020, 6'd1, 8'd0, 2'b01);
        w_send(32'hFFFFFFFF, 4'hF, 1'b1);
        b_recv(6'd1, 2'b00);
        aw_send(15'h0020, 6'd2, 8'd0, 2'b01);
        w_send(32'h12345678, 4'b0101, 1'b1);
        b_recv(6'd2, 2'b00);
        ar_send(15'h0020, 6'd3, 8'd0, 2'b01);
        r_recv("t3", 32'hFF34FF78, 6'd3, 2'b00, 1'b1);

        // 4: B back-pressure, then R stalls every other cycle
        aw_send(15'h0030, 6'd4, 8'd0, 2'b01);
        w_send(32'h00000055, 4'hF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            check("t4_bvalid_held", 32'(bvalid), 32'd1);
            check("t4_awready_low", 32'(awready), 32'd0);
            tick();
        end
        b_recv(6'd4, 2'b00);
        check("t4_awready_back", 32'(awready), 32'd1);
        ar_send(15'h00F8, 6'd6, 8'd3, 2'b01);
        tick();
        for (int b = 0; b < 4; b++) begin
            rready = 1'b0;
            tick();
            check("t4_stall_rvalid", 32'(rvalid), 32'd1);
            check("t4_stall_rdata", rdata, exp4[b]);
            rready = 1'b1;
            check("t4_rlast", 32'(rlast), 32'(b == 3));
            tick();
        end
        rready = 1'b0;
        check("t4_rvalid_done", 32'(rvalid), 32'd0);

        // 5: out-of-page address 0x4000 maps to index 0 (holds 3)
        aw_send(15'h4000, 6'd10, 8'd0, 2'b01);
        w_send(32'hA5A5A5A5, 4'hF, 1'b1);
`ifdef REG_ERR_RESP_EN
        b_recv(6'd10, 2'b10);
        ar_send(15'h4000, 6'd11, 8'd0, 2'b01);
        r_recv("t5_err", 32'd0, 6'd11, 2'b10, 1'b1);
        ar_send(15'h0000, 6'd12, 8'd0, 2'b01);
        r_recv("t5_idx0", 32'd3, 6'd12, 2'b00, 1'b1);
`else
        b_recv(6'd10, 2'b00);
        ar_send(15'h0000, 6'd12, 8'd0, 2'b01);
        r_recv("t5_idx0", 32'hA5A5A5A5, 6'd12, 2'b00, 1'b1);
`endif

        // 6: mid-burst reset with early WLAST
        ar_send(15'h0000, 6'd3, 8'd7, 2'b01);
        aw_send(15'h0040, 6'd9, 8'd7, 2'b01);
        w_send(32'd11, 4'hF, 1'b0);
        w_send(32'd12, 4'hF, 1'b0);
        w_send(32'd13, 4'hF, 1'b1);
        check("t6_err_wlast", 32'(err_wlast), 32'd1);
        check("t6_rvalid_inflight", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        tick();
        check_all_zero("t6_reset");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_no_stray_b", 32'(bvalid), 32'd0);
            check("t6_no_stray_r", 32'(rvalid), 32'd0);
        end
        ar_send(15'h00F8, 6'd1, 8'd1, 2'b01);
        r_recv("t6_clr62", 32'd0, 6'd1, 2'b00, 1'b0);
        r_recv("t6_clr63", 32'd0, 6'd1, 2'b00, 1'b1);
        ar_send(15'h0020, 6'd2, 8'd0, 2'b01);
        r_recv("t6_clr8", 32'd0, 6'd2, 2'b00, 1'b1);
        aw_send(15'h0044, 6'd20, 8'd0, 2'b01);
        w_send(32'hCAFEF00D, 4'hF, 1'b1);
        b_recv(6'd20, 2'b00);
        ar_send(15'h0044, 6'd21, 8'd0, 2'b01);
        r_recv("t6_after", 32'hCAFEF00D, 6'd21, 2'b00, 1'b1);
        check("t6_err_wlast_clear", 32'(err_wlast), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
